// File: rtl/rv32i_clint_pkg.sv
// rtl/rv32i_clint_pkg.sv - shared register offsets, state encoding and reset constants for the CLINT
package rv32i_clint_pkg;

    localparam logic [15:0] MSIP_OFF        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

    localparam logic [63:0] MTIMECMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } clint_state_e;

endpackage

// File: rtl/rv32i_clint_bytemerge.sv
// rtl/rv32i_clint_bytemerge.sv - replaces one 32-bit half of a 64-bit shadow byte-wise under a mask
module rv32i_clint_bytemerge (
    input  logic [63:0] shadow_i,
    input  logic        hi_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  mask_i,
    output logic [63:0] merged_o
);

    logic [31:0] half;
    logic [31:0] new_half;

    always_comb begin
        half     = hi_i ? shadow_i[63:32] : shadow_i[31:0];
        new_half = half;
        for (int b = 0; b < 4; b++) begin
            if (mask_i[b]) begin
                new_half[8*b +: 8] = data_i[8*b +: 8];
            end
        end
        merged_o = hi_i ? {new_half, shadow_i[31:0]} : {shadow_i[63:32], new_half};
    end

endmodule

// File: rtl/rv32i_clint.sv
// rtl/rv32i_clint.sv - memory-mapped CLINT: msip bit, mtime/mtimecmp mirrors and core timer write pulses
module rv32i_clint
    import rv32i_clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          CLK_FREQ_MHZ = 100
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_daddr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wr_mask,
    input  logic        i_wr_en,
    output logic        o_hit,
    output logic        o_rd_sel,
    output logic [31:0] o_rdata,
    output logic        o_software_interrupt,
    output logic        o_mtime_wr,
    output logic [63:0] o_mtime_din,
    output logic        o_mtimecmp_wr,
    output logic [63:0] o_mtimecmp_din
);

    localparam int PW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;

    clint_state_e state_q, state_d;

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;

    logic        rd_sel_q;
    logic [31:0] rdata_q;
    logic        mtime_wr_q, mtimecmp_wr_q;
    logic [63:0] mtime_din_q, mtimecmp_din_q;

    logic [15:0] off;
    logic        init_wr, run;
    logic        store, mtime_st, mtimecmp_st, msip_st, tick;
    logic [63:0] mtime_merged, mtimecmp_merged;
    logic [31:0] rd_val;

    // Word-aligned decode: the byte offset within a word never matters.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^i_daddr[1:0];

    assign o_hit = (i_daddr[31:16] == BASE_ADDR[31:16]);
    assign off   = {i_daddr[15:2], 2'b00};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        init_wr = (state_q == INIT);
        run     = (state_q == RUN);
    end

    assign store       = i_wr_en && o_hit && run;
    assign mtime_st    = store && ((off == MTIME_LO_OFF) || (off == MTIME_HI_OFF));
    assign mtimecmp_st = store && ((off == MTIMECMP_LO_OFF) || (off == MTIMECMP_HI_OFF));
    assign msip_st     = store && (off == MSIP_OFF);
    assign tick        = run && (presc_q == PW'(CLK_FREQ_MHZ - 1));

    rv32i_clint_bytemerge u_mtime_merge (
        .shadow_i (mtime_q),
        .hi_i     (off == MTIME_HI_OFF),
        .data_i   (i_wdata),
        .mask_i   (i_wr_mask),
        .merged_o (mtime_merged)
    );

    rv32i_clint_bytemerge u_mtimecmp_merge (
        .shadow_i (mtimecmp_q),
        .hi_i     (off == MTIMECMP_HI_OFF),
        .data_i   (i_wdata),
        .mask_i   (i_wr_mask),
        .merged_o (mtimecmp_merged)
    );

    // A store to mtime overrides a coinciding tick and restarts the microsecond count.
    always_comb begin
        mtime_d    = mtime_q;
        presc_d    = presc_q + PW'(1);
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (init_wr) begin
            mtime_d    = '0;
            presc_d    = '0;
            mtimecmp_d = MTIMECMP_RESET;
        end else begin
            if (mtime_st) begin
                mtime_d = mtime_merged;
                presc_d = '0;
            end else if (tick) begin
                mtime_d = mtime_q + 64'd1;
                presc_d = '0;
            end
            if (mtimecmp_st) begin
                mtimecmp_d = mtimecmp_merged;
            end
            if (msip_st && i_wr_mask[0]) begin
                msip_d = i_wdata[0];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (off)
            MSIP_OFF:        rd_val = {31'd0, msip_q};
            MTIMECMP_LO_OFF: rd_val = mtimecmp_q[31:0];
            MTIMECMP_HI_OFF: rd_val = mtimecmp_q[63:32];
            MTIME_LO_OFF:    rd_val = mtime_q[31:0];
            MTIME_HI_OFF:    rd_val = mtime_q[63:32];
            default:         rd_val = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q        <= '0;
            mtime_q        <= '0;
            mtimecmp_q     <= MTIMECMP_RESET;
            msip_q         <= 1'b0;
            rd_sel_q       <= 1'b0;
            rdata_q        <= '0;
            mtime_wr_q     <= 1'b0;
            mtimecmp_wr_q  <= 1'b0;
            mtime_din_q    <= '0;
            mtimecmp_din_q <= '0;
        end else begin
            presc_q       <= presc_d;
            mtime_q       <= mtime_d;
            mtimecmp_q    <= mtimecmp_d;
            msip_q        <= msip_d;
            rd_sel_q      <= o_hit;
            rdata_q       <= o_hit ? rd_val : 32'd0;
            mtime_wr_q    <= init_wr || mtime_st;
            mtimecmp_wr_q <= init_wr || mtimecmp_st;
            if (init_wr || mtime_st) begin
                mtime_din_q <= mtime_d;
            end
            if (init_wr || mtimecmp_st) begin
                mtimecmp_din_q <= mtimecmp_d;
            end
        end
    end

    assign o_rd_sel             = rd_sel_q;
    assign o_rdata              = rdata_q;
    assign o_software_interrupt = msip_q;
    assign o_mtime_wr           = mtime_wr_q;
    assign o_mtime_din          = mtime_din_q;
    assign o_mtimecmp_wr        = mtimecmp_wr_q;
    assign o_mtimecmp_din       = mtimecmp_din_q;

endmodule
